// File: rtl/cv32e40p_lce_pkg.sv
// Shared types and helpers for the multi-channel basic-block length monitor.
// Holds the channel state encoding, the limit clamp and default constants.
package cv32e40p_lce_pkg;

   typedef enum logic [1:0] {
      LCE_DISABLED = 2'd0,
      LCE_COUNTING = 2'd1,
      LCE_EXPIRED  = 2'd2
   } lce_state_e;

   localparam int LCE_MAX_BB_LEN_DEFAULT = 32;
   localparam int LCE_EVT_W_DEFAULT      = 8;

   // A zero limit would expire without any retirement, so it is raised to one.
   function automatic logic [31:0] lce_clamp(input logic [31:0] value, input logic [31:0] max_val);
      logic [31:0] res;
      if (value == 32'd0) begin
         res = 32'd1;
      end else if (value > max_val) begin
         res = max_val;
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/cv32e40p_lce_channel.sv
// One monitor channel: state machine, down-counter, limit, sticky alarm and
// saturating expiry-event counter.
module cv32e40p_lce_channel
   import cv32e40p_lce_pkg::*;
#(
   parameter int MAX_BB_LEN = LCE_MAX_BB_LEN_DEFAULT,
   parameter int EVT_W      = LCE_EVT_W_DEFAULT,
   parameter int CNT_W      = $clog2(MAX_BB_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_limit,
   input  logic             cfg_en,
   input  logic             init,
   input  logic             decrement,
   input  logic             alarm_ack,
   output logic             expired,
   output logic             alarm,
   output logic [CNT_W-1:0] count,
   output logic [EVT_W-1:0] evt_cnt
);

   lce_state_e       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [CNT_W-1:0] limit_r, limit_s;
   logic             alarm_r, alarm_s;
   logic [EVT_W-1:0] evt_r, evt_s;
   logic             expire_s;
   logic             disable_s;

   // Next-state, counter reload/decrement, alarm and event-counter update.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      expire_s  = 1'b0;
      disable_s = cfg_we && !cfg_en;
      if (cfg_we) begin
         limit_s = CNT_W'(lce_clamp(32'(cfg_limit), 32'(MAX_BB_LEN)));
      end else begin
         limit_s = limit_r;
      end
      case (state_r)
         LCE_DISABLED: begin
            cnt_s = limit_s;
            if (cfg_we && cfg_en) begin
               state_s = LCE_COUNTING;
            end else begin
               state_s = LCE_DISABLED;
            end
         end
         LCE_COUNTING: begin
            // init reloads with the limit in force before any same-cycle write
            if (disable_s) begin
               state_s = LCE_DISABLED;
               cnt_s   = limit_s;
            end else if (init) begin
               cnt_s = limit_r;
            end else if (decrement) begin
               if (cnt_r > CNT_W'(1)) begin
                  cnt_s = cnt_r - CNT_W'(1);
               end else begin
                  cnt_s    = {CNT_W{1'b0}};
                  state_s  = LCE_EXPIRED;
                  expire_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         LCE_EXPIRED: begin
            if (disable_s) begin
               state_s = LCE_DISABLED;
               cnt_s   = limit_s;
            end else if (init) begin
               state_s = LCE_COUNTING;
               cnt_s   = limit_r;
            end else begin
               cnt_s = {CNT_W{1'b0}};
            end
         end
         default: begin
            state_s = LCE_DISABLED;
            cnt_s   = limit_s;
         end
      endcase
      alarm_s = expire_s || (alarm_r && !alarm_ack);
      if (expire_s && (evt_r != {EVT_W{1'b1}})) begin
         evt_s = evt_r + EVT_W'(1);
      end else begin
         evt_s = evt_r;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= LCE_COUNTING;
         cnt_r   <= CNT_W'(MAX_BB_LEN);
         limit_r <= CNT_W'(MAX_BB_LEN);
         alarm_r <= 1'b0;
         evt_r   <= {EVT_W{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         limit_r <= limit_s;
         alarm_r <= alarm_s;
         evt_r   <= evt_s;
      end
   end

   assign expired = (state_r == LCE_EXPIRED);
   assign alarm   = alarm_r;
   assign count   = cnt_r;
   assign evt_cnt = evt_r;

endmodule

// File: rtl/cv32e40p_lce_monitor.sv
// Multi-channel basic-block length monitor: decodes config writes to one
// channel, instantiates the channels and packs their outputs.
module cv32e40p_lce_monitor
   import cv32e40p_lce_pkg::*;
#(
   parameter  int NUM_CH     = 2,
   parameter  int MAX_BB_LEN = LCE_MAX_BB_LEN_DEFAULT,
   parameter  int EVT_W      = LCE_EVT_W_DEFAULT,
   localparam int CNT_W      = $clog2(MAX_BB_LEN + 1),
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_we_i,
   input  logic [CH_W-1:0]         cfg_ch_i,
   input  logic [CNT_W-1:0]        cfg_limit_i,
   input  logic                    cfg_en_i,
   input  logic [NUM_CH-1:0]       init_i,
   input  logic [NUM_CH-1:0]       decrement_i,
   input  logic [NUM_CH-1:0]       alarm_ack_i,
   output logic [NUM_CH-1:0]       expired_o,
   output logic [NUM_CH-1:0]       alarm_o,
   output logic                    alarm_any_o,
   output logic [NUM_CH*CNT_W-1:0] count_o,
   output logic [NUM_CH*EVT_W-1:0] evt_cnt_o
);

   logic [NUM_CH-1:0] ch_we_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_we_s[i] = cfg_we_i && (cfg_ch_i == CH_W'(i));

      cv32e40p_lce_channel #(
         .MAX_BB_LEN (MAX_BB_LEN),
         .EVT_W      (EVT_W),
         .CNT_W      (CNT_W)
      ) u_channel (
         .clk       (clk),
         .rst_n     (rst_n),
         .cfg_we    (ch_we_s[i]),
         .cfg_limit (cfg_limit_i),
         .cfg_en    (cfg_en_i),
         .init      (init_i[i]),
         .decrement (decrement_i[i]),
         .alarm_ack (alarm_ack_i[i]),
         .expired   (expired_o[i]),
         .alarm     (alarm_o[i]),
         .count     (count_o[i*CNT_W +: CNT_W]),
         .evt_cnt   (evt_cnt_o[i*EVT_W +: EVT_W])
      );
   end

   assign alarm_any_o = |alarm_o;

endmodule

// File: tb/tb_cv32e40p_lce_monitor.sv
// Self-checking bench: directed scenarios plus random traffic, every output
// compared each cycle against a per-channel behavioural model.
module tb_cv32e40p_lce_monitor;

   localparam int NCH  = 4;
   localparam int MAXL = 32;
   localparam int CW   = 6;
   localparam int EW   = 8;
   localparam int EMAX = 255;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_we = 1'b0;
   logic [1:0]        cfg_ch = 2'd0;
   logic [CW-1:0]     cfg_limit = '0;
   logic              cfg_en = 1'b1;
   logic [NCH-1:0]    init = '0;
   logic [NCH-1:0]    dec = '0;
   logic [NCH-1:0]    ack = '0;
   logic [NCH-1:0]    expired_o;
   logic [NCH-1:0]    alarm_o;
   logic              alarm_any_o;
   logic [NCH*CW-1:0] count_o;
   logic [NCH*EW-1:0] evt_cnt_o;

   int n_vec = 0;
   int n_miscmp = 0;

   int m_cnt [NCH];
   int m_lim [NCH];
   int m_evt [NCH];
   bit m_en [NCH];
   bit m_alarm [NCH];

   cv32e40p_lce_monitor #(.NUM_CH(NCH), .MAX_BB_LEN(MAXL), .EVT_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
      .cfg_limit_i(cfg_limit), .cfg_en_i(cfg_en), .init_i(init),
      .decrement_i(dec), .alarm_ack_i(ack), .expired_o(expired_o),
      .alarm_o(alarm_o), .alarm_any_o(alarm_any_o), .count_o(count_o),
      .evt_cnt_o(evt_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = MAXL; m_lim[i] = MAXL; m_evt[i] = 0; m_en[i] = 1'b1; m_alarm[i] = 1'b0;
      end
   endtask

   // One clock edge of the monitor, computed from the behavioural rules.
   task automatic model_step();
      for (int i = 0; i < NCH; i++) begin
         bit we, hit;
         int nl, old;
         we  = cfg_we && (int'(cfg_ch) == i);
         nl  = (cfg_limit == 0) ? 1 : ((int'(cfg_limit) > MAXL) ? MAXL : int'(cfg_limit));
         hit = 1'b0;
         if (!m_en[i]) begin
            if (we) begin m_lim[i] = nl; m_en[i] = cfg_en; end
            m_cnt[i] = m_lim[i];
         end else if (we && !cfg_en) begin
            m_en[i] = 1'b0; m_lim[i] = nl; m_cnt[i] = nl;
         end else begin
            old = m_lim[i];
            if (we) m_lim[i] = nl;
            if (init[i]) m_cnt[i] = old;
            else if (dec[i] && m_cnt[i] > 0) begin
               m_cnt[i]--;
               hit = (m_cnt[i] == 0);
            end
         end
         m_alarm[i] = hit || (m_alarm[i] && !ack[i]);
         if (hit && m_evt[i] < EMAX) m_evt[i]++;
      end
   endtask

   task automatic compare_all();
      bit any;
      any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         check_val($sformatf("count[%0d]", i), 32'(count_o[i*CW +: CW]), 32'(m_cnt[i]));
         check_val($sformatf("expired[%0d]", i), 32'(expired_o[i]), 32'(m_en[i] && m_cnt[i] == 0));
         check_val($sformatf("alarm[%0d]", i), 32'(alarm_o[i]), 32'(m_alarm[i]));
         check_val($sformatf("evt_cnt[%0d]", i), 32'(evt_cnt_o[i*EW +: EW]), 32'(m_evt[i]));
         any |= m_alarm[i];
      end
      check_val("alarm_any", 32'(alarm_any_o), 32'(any));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      cfg_we = 1'b0; init = '0; dec = '0; ack = '0;
   endtask

   task automatic write_cfg(input int ch, input int lim, input bit en);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_limit = CW'(lim); cfg_en = en;
      tick();
   endtask

   task automatic pulse(input logic [NCH-1:0] i_m, input logic [NCH-1:0] d_m,
                        input logic [NCH-1:0] a_m, input int n);
      for (int k = 0; k < n; k++) begin
         init = i_m; dec = d_m; ack = a_m;
         tick();
      end
   endtask

   initial begin
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Default limit: 32 retirements expire channel 0 only.
      pulse(4'b0000, 4'b0001, 4'b0000, 32);
      check_val("ch0_expired_after_32", 32'(expired_o[0]), 32'd1);
      check_val("ch1_untouched", 32'(count_o[CW +: CW]), 32'd32);

      // Channel 1 with limit 5, overrun without wrap, init keeps sticky alarm.
      write_cfg(1, 5, 1'b1);
      pulse(4'b0010, 4'b0000, 4'b0000, 1);
      pulse(4'b0000, 4'b0010, 4'b0000, 8);
      check_val("ch1_no_wrap", 32'(count_o[CW +: CW]), 32'd0);
      pulse(4'b0010, 4'b0000, 4'b0000, 1);
      check_val("ch1_alarm_after_init", 32'(alarm_o[1]), 32'd1);
      pulse(4'b0000, 4'b0000, 4'b0010, 1);

      // init wins over decrement; ack loses against a simultaneous expiry.
      pulse(4'b0000, 4'b0010, 4'b0000, 2);
      pulse(4'b0010, 4'b0010, 4'b0000, 1);
      check_val("init_beats_dec", 32'(count_o[CW +: CW]), 32'd5);
      pulse(4'b0000, 4'b0010, 4'b0000, 4);
      pulse(4'b0000, 4'b0010, 4'b0010, 1);
      check_val("set_beats_ack", 32'(alarm_o[1]), 32'd1);

      // Limit clamping on channel 2, disable/re-enable on channel 3.
      write_cfg(2, 0, 1'b1);
      pulse(4'b0100, 4'b0000, 4'b0000, 1);
      check_val("clamp_low", 32'(count_o[2*CW +: CW]), 32'd1);
      pulse(4'b0000, 4'b0100, 4'b0000, 1);
      write_cfg(2, 40, 1'b1);
      pulse(4'b0100, 4'b0000, 4'b0000, 1);
      check_val("clamp_high", 32'(count_o[2*CW +: CW]), 32'd32);
      write_cfg(3, 20, 1'b1);
      pulse(4'b1000, 4'b0000, 4'b0000, 1);
      pulse(4'b0000, 4'b1000, 4'b0000, 13);
      write_cfg(3, 20, 1'b0);
      pulse(4'b0000, 4'b1000, 4'b0000, 50);
      check_val("disabled_no_alarm", 32'(alarm_o[3]), 32'd0);
      write_cfg(3, 20, 1'b1);
      pulse(4'b0000, 4'b1000, 4'b0000, 3);

      // 300 expiries on channel 0 saturate its event counter.
      write_cfg(0, 1, 1'b1);
      for (int k = 0; k < 300; k++) begin
         pulse(4'b0001, 4'b0000, 4'b0000, 1);
         pulse(4'b0000, 4'b0001, 4'b0000, 1);
      end
      check_val("evt_saturated", 32'(evt_cnt_o[EW-1:0]), 32'd255);

      // Asynchronous reset mid-count takes effect without a clock edge.
      pulse(4'b0000, 4'b1111, 4'b0000, 3);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Random interleaved traffic on all channels.
      for (int k = 0; k < 3000; k++) begin
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_limit = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 63)) : CW'($urandom_range(0, 6));
         cfg_en    = ($urandom_range(0, 5) != 0);
         init      = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
         dec       = NCH'($urandom) | NCH'($urandom);
         ack       = NCH'($urandom) & NCH'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
